// File: rtl/uart_rx_msg_collector.sv
// uart_rx_msg_collector: qualifies UART receiver bytes and assembles NUM_BYTES good bytes into one message word
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-high reset
//   i_start_bit_found   receiver detected a start bit
//   i_rx_data           received character
//   i_rx_ferror         framing error for i_rx_data
//   i_rx_perror         parity error for i_rx_data
//   i_rx_valid          data/flags valid (level, may be held several cycles)
//   o_rx_en             receiver enable
//   o_rx_baud_select    baud select, tied to BAUD_SEL
//   o_msg_data          last complete message, first byte in the MS lane
//   o_msg_valid         one-cycle strobe: o_msg_data just updated
//   o_msg_abort         one-cycle strobe: partial message discarded
//   o_byte_idx          bytes collected in the current message
//   o_ferr_count        framing errors seen, saturating
//   o_perr_count        parity errors seen, saturating
//
// Optional feature: define RX_TIMEOUT_EN to abort a partial message after
// TIMEOUT_CYCLES clocks without a capture event.
module uart_rx_msg_collector #(
   parameter int         DATA_W         = 8,
   parameter int         NUM_BYTES      = 4,
   parameter logic [2:0] BAUD_SEL       = 3'b111,
   parameter int         CNT_W          = 8,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_start_bit_found,
   input  logic [DATA_W-1:0]             i_rx_data,
   input  logic                          i_rx_ferror,
   input  logic                          i_rx_perror,
   input  logic                          i_rx_valid,
   output logic                          o_rx_en,
   output logic [2:0]                    o_rx_baud_select,
   output logic [NUM_BYTES*DATA_W-1:0]   o_msg_data,
   output logic                          o_msg_valid,
   output logic                          o_msg_abort,
   output logic [$clog2(NUM_BYTES)-1:0]  o_byte_idx,
   output logic [CNT_W-1:0]              o_ferr_count,
   output logic [CNT_W-1:0]              o_perr_count
);
   localparam int IW = $clog2(NUM_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT} state_t;

   state_t                        r_state;
   state_t                        w_next;
   logic                          r_valid_d;
   logic [NUM_BYTES*DATA_W-1:0]   r_buf;
   logic [NUM_BYTES*DATA_W-1:0]   r_msg;
   logic                          r_msg_valid;
   logic                          r_msg_abort;
   logic [IW-1:0]                 r_byte_idx;
   logic [CNT_W-1:0]              r_ferr_cnt;
   logic [CNT_W-1:0]              r_perr_cnt;
   logic                          w_cap;
   logic                          w_good;
   logic                          w_bad;
   logic                          w_last;
   logic                          w_expire;

   // Only a rising edge of the valid level is a capture; it counts only while waiting for a byte.
   assign w_cap  = i_rx_valid && !r_valid_d;
   assign w_good = (r_state == S_WAIT) && w_cap && !(i_rx_ferror || i_rx_perror);
   assign w_bad  = (r_state == S_WAIT) && w_cap && (i_rx_ferror || i_rx_perror);
   assign w_last = r_byte_idx == IW'(NUM_BYTES - 1);

`ifdef RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;
   logic          w_to_run;
   // COMMIT is excluded so a completing message can never be aborted.
   assign w_to_run = (r_byte_idx != '0 || r_state == S_WAIT) && r_state != S_COMMIT;
   // A capture in the expiry cycle wins over the timeout.
   assign w_expire = w_to_run && !w_cap && r_to_cnt == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk) begin
      if (reset || w_cap || !w_to_run || w_expire) r_to_cnt <= '0;
      else r_to_cnt <= r_to_cnt + 1'b1;
   end
`else
   // Timeout disabled: expiry is constant false.
   assign w_expire = TIMEOUT_CYCLES < 0;
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = i_start_bit_found ? S_WAIT : S_IDLE;
         S_WAIT:   w_next = (w_good && w_last) ? S_COMMIT : (w_good || w_bad || w_expire) ? S_IDLE : S_WAIT;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb o_rx_en = r_state == S_WAIT;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid_d   <= 1'b0;
         r_buf       <= '0;
         r_msg       <= '0;
         r_msg_valid <= 1'b0;
         r_msg_abort <= 1'b0;
         r_byte_idx  <= '0;
         r_ferr_cnt  <= '0;
         r_perr_cnt  <= '0;
      end else begin
         r_valid_d   <= i_rx_valid;
         r_msg_valid <= r_state == S_COMMIT;
         r_msg_abort <= w_bad || w_expire;
         if (r_state == S_COMMIT) r_msg <= r_buf;
         // Lane k sits at the top minus k lanes so the first byte is most significant.
         if (w_good) r_buf[(NUM_BYTES - 1 - int'(r_byte_idx))*DATA_W +: DATA_W] <= i_rx_data;
         if (w_bad || w_expire || r_state == S_COMMIT) r_byte_idx <= '0;
         else if (w_good && !w_last) r_byte_idx <= r_byte_idx + 1'b1;
         if (w_bad && i_rx_ferror && r_ferr_cnt != '1) r_ferr_cnt <= r_ferr_cnt + 1'b1;
         if (w_bad && i_rx_perror && r_perr_cnt != '1) r_perr_cnt <= r_perr_cnt + 1'b1;
      end
   end

   assign o_rx_baud_select = BAUD_SEL;
   assign o_msg_data       = r_msg;
   assign o_msg_valid      = r_msg_valid;
   assign o_msg_abort      = r_msg_abort;
   assign o_byte_idx       = r_byte_idx;
   assign o_ferr_count     = r_ferr_cnt;
   assign o_perr_count     = r_perr_cnt;
endmodule

// File: tb/tb_uart_rx_msg_collector.sv
// tb_uart_rx_msg_collector: scoreboard bench for uart_rx_msg_collector with a message-level reference model
module tb_uart_rx_msg_collector;
   localparam int NB = 4;
   localparam int DW = 8;

   typedef struct {
      bit          abort;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_bit_found = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ferror = 1'b0;
   logic        rx_perror = 1'b0;
   logic        rx_valid = 1'b0;
   logic        rx_en;
   logic [2:0]  rx_baud_select;
   logic [31:0] msg_data;
   logic        msg_valid;
   logic        msg_abort;
   logic [1:0]  byte_idx;
   logic [7:0]  ferr_count;
   logic [7:0]  perr_count;

   int          checks = 0;
   int          errors = 0;
   exp_t        q[$];
   logic [7:0]  coll[$];
   logic [31:0] last_msg = '0;
   int          fcnt = 0;
   int          pcnt = 0;

   uart_rx_msg_collector #(
      .DATA_W(DW), .NUM_BYTES(NB), .BAUD_SEL(3'b111), .CNT_W(8), .TIMEOUT_CYCLES(50)
   ) dut (
      .clk(clk), .reset(reset), .i_start_bit_found(start_bit_found), .i_rx_data(rx_data),
      .i_rx_ferror(rx_ferror), .i_rx_perror(rx_perror), .i_rx_valid(rx_valid),
      .o_rx_en(rx_en), .o_rx_baud_select(rx_baud_select), .o_msg_data(msg_data),
      .o_msg_valid(msg_valid), .o_msg_abort(msg_abort), .o_byte_idx(byte_idx),
      .o_ferr_count(ferr_count), .o_perr_count(perr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe from the DUT must match the oldest expected event.
   always @(negedge clk) begin
      if (!reset && (msg_valid || msg_abort)) begin
         exp_t e;
         chk("valid_abort_exclusive", 32'(msg_valid & msg_abort), 32'd0);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: valid=%0b abort=%0b data=%0h, expected none", msg_valid, msg_abort, msg_data);
         end else begin
            e = q.pop_front();
            chk("out_kind_abort", 32'(msg_abort), 32'(e.abort));
            chk("out_msg_data", msg_data, e.data);
         end
      end
   end

   // Reference model: bytes accumulate in a list; a full list becomes a message, an error empties it.
   task automatic model_byte(input logic [7:0] d, input bit fe, input bit pe, output bit commit);
      commit = 1'b0;
      if (fe || pe) begin
         if (fe && fcnt < 255) fcnt++;
         if (pe && pcnt < 255) pcnt++;
         coll.delete();
         q.push_back('{1'b1, last_msg});
      end else begin
         coll.push_back(d);
         if (coll.size() == NB) begin
            last_msg = {coll[0], coll[1], coll[2], coll[3]};
            q.push_back('{1'b0, last_msg});
            coll.delete();
            commit = 1'b1;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input bit fe, input bit pe, input int hold);
      bit         commit;
      logic [1:0] lat;
      model_byte(d, fe, pe, commit);
      @(negedge clk) start_bit_found = 1'b1;
      @(negedge clk) start_bit_found = 1'b0;
      chk("rx_en_wait", 32'(rx_en), 32'd1);
      rx_data = d;
      rx_ferror = fe;
      rx_perror = pe;
      rx_valid = 1'b1;
      lat = '0;
      for (int i = 1; i <= hold + 2; i++) begin
         @(negedge clk);
         if (i <= 2) lat[2-i] = msg_valid;
         if (i == hold) rx_valid = 1'b0;
      end
      chk("valid_latency", 32'(lat), 32'({1'b0, commit}));
      chk("byte_idx", 32'(byte_idx), 32'(coll.size()));
      chk("rx_en_idle", 32'(rx_en), 32'd0);
      rx_ferror = 1'b0;
      rx_perror = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_rx_en"}, 32'(rx_en), 32'd0);
      chk({tag, "_msg_data"}, msg_data, 32'd0);
      chk({tag, "_msg_valid"}, 32'(msg_valid), 32'd0);
      chk({tag, "_msg_abort"}, 32'(msg_abort), 32'd0);
      chk({tag, "_byte_idx"}, 32'(byte_idx), 32'd0);
      chk({tag, "_ferr"}, 32'(ferr_count), 32'd0);
      chk({tag, "_perr"}, 32'(perr_count), 32'd0);
      chk({tag, "_baud"}, 32'(rx_baud_select), 32'h7);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] seq1 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      @(negedge clk);

      foreach (seq1[i]) send_byte(seq1[i], 1'b0, 1'b0, 1);
      chk("t1_msg", msg_data, 32'h12345678);

      send_byte(8'hAA, 1'b0, 1'b0, 2);
      send_byte(8'hBB, 1'b0, 1'b0, 1);
      send_byte(8'hCC, 1'b0, 1'b1, 1);
      chk("t2_perr", 32'(perr_count), 32'd1);
      chk("t2_ferr", 32'(ferr_count), 32'd0);
      chk("t2_msg_kept", msg_data, 32'h12345678);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, 1'b0, 1);
      chk("t2_msg", msg_data, 32'h01020304);

      send_byte(8'h11, 1'b0, 1'b0, 10);
      @(negedge clk) rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
      chk("idle_rise_ignored", 32'(byte_idx), 32'd1);
      for (int i = 0; i < 3; i++) send_byte(8'h20 + 8'(i), 1'b0, 1'b0, 3);
      chk("hold_msg", msg_data, 32'h11202122);

      repeat (150) begin
         send_byte(8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(1, 4));
      end
      chk("rand_ferr", 32'(ferr_count), 32'(fcnt));
      chk("rand_perr", 32'(perr_count), 32'(pcnt));

      send_byte(8'h00, 1'b1, 1'b1, 1);
      chk("both_ferr", 32'(ferr_count), 32'(fcnt));
      chk("both_perr", 32'(perr_count), 32'(pcnt));
      repeat (300) send_byte(8'($urandom), 1'b1, 1'b1, 1);
      chk("sat_ferr", 32'(ferr_count), 32'hFF);
      chk("sat_perr", 32'(perr_count), 32'hFF);

      send_byte(8'h9A, 1'b0, 1'b0, 1);
      send_byte(8'hBC, 1'b0, 1'b0, 1);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      check_reset_values("midreset");
      reset = 1'b0;
      coll.delete();
      last_msg = '0;
      fcnt = 0;
      pcnt = 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0, 2);
      chk("fresh_msg", msg_data, 32'hC0C1C2C3);

      send_byte(8'h5A, 1'b0, 1'b0, 1);
`ifdef RX_TIMEOUT_EN
      q.push_back('{1'b1, last_msg});
      coll.delete();
`endif
      repeat (60) @(negedge clk);
      chk("timeout_byte_idx", 32'(byte_idx), 32'(coll.size()));
      chk("timeout_counters", 32'({ferr_count, perr_count}), 32'd0);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drain", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
